// File: rtl/spike_gen_scheduler.sv
// spike_gen_scheduler
//   Holds per-generator period/countdown/tag state, accepts programming while
//   idle, and on each time-unit pulse walks all 2**Ngens generators in order,
//   emitting one tag/count event per expiring generator.
//
// Ports
//   clk, reset          : sole clock; synchronous active-high reset
//   time_unit_pulse     : one-cycle time-unit strobe from TimeMgr
//   prog_gen_idx/period/ticks/tag, prog_v -> prog_a : programming channel
//   out_tag/out_ct/out_v -> out_a                   : emitted event channel
//   busy                : high whenever not IDLE
//   overrun             : sticky, a pulse arrived while one was pending
//
// Optional feature (macro SPIKE_GEN_STATS_EN)
//   spike_count[31:0]   : count of out handshakes, wraps modulo 2**32
//   clear_stats         : synchronous clear, wins over a coincident handshake
module spike_gen_scheduler #(
  parameter int Ngens   = 8,
  parameter int Nperiod = 16,
  parameter int Ntag    = 11,
  parameter int Nct     = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               time_unit_pulse,
  input  logic [Ngens-1:0]   prog_gen_idx,
  input  logic [Nperiod-1:0] prog_period,
  input  logic [Nperiod-1:0] prog_ticks,
  input  logic [Ntag-1:0]    prog_tag,
  input  logic               prog_v,
  output logic               prog_a,
  output logic [Ntag-1:0]    out_tag,
  output logic [Nct-1:0]     out_ct,
  output logic               out_v,
  input  logic               out_a,
  output logic               busy,
  output logic               overrun
`ifdef SPIKE_GEN_STATS_EN
  ,
  output logic [31:0]        spike_count,
  input  logic               clear_stats
`endif
);

  localparam int NGEN = 2**Ngens;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_EMIT = 2'd2;

  logic [1:0]         state;
  logic [Ngens-1:0]   idx;
  logic               pending;
  logic [NGEN-1:0]    en;
  logic [Nperiod-1:0] period_mem [NGEN];
  logic [Nperiod-1:0] ticks_mem  [NGEN];
  logic [Ntag-1:0]    tag_mem    [NGEN];

  logic start;
  logic last;
  logic expired;
  logic xfer;

  always_comb begin
    start   = time_unit_pulse | pending;
    last    = (idx == '1);
    // ticks==0 on an enabled generator counts as expired
    expired = (ticks_mem[idx] <= Nperiod'(1));
    xfer    = out_v & out_a;
    busy    = (state != ST_IDLE);
    // A pulse (or pending scan) takes priority over programming in IDLE
    prog_a  = (state == ST_IDLE) & ~start & ~reset;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      idx     <= '0;
      pending <= 1'b0;
      overrun <= 1'b0;
      en      <= '0;
      out_v   <= 1'b0;
      out_tag <= '0;
      out_ct  <= '0;
    end else begin
      if (time_unit_pulse && pending)
        overrun <= 1'b1;
      if (time_unit_pulse && state != ST_IDLE)
        pending <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (start) begin
            state   <= ST_SCAN;
            idx     <= '0;
            pending <= 1'b0;
          end else if (prog_v) begin
            period_mem[prog_gen_idx] <= prog_period;
            ticks_mem[prog_gen_idx]  <= prog_ticks;
            tag_mem[prog_gen_idx]    <= prog_tag;
            en[prog_gen_idx]         <= (prog_period != '0);
          end
        end

        ST_SCAN: begin
          if (en[idx] && expired) begin
            // idx is held so EMIT can reload this generator on handshake
            out_tag <= tag_mem[idx];
            out_ct  <= Nct'(1);
            out_v   <= 1'b1;
            state   <= ST_EMIT;
          end else begin
            if (en[idx])
              ticks_mem[idx] <= ticks_mem[idx] - Nperiod'(1);
            if (last)
              state <= ST_IDLE;
            else
              idx <= idx + Ngens'(1);
          end
        end

        ST_EMIT: begin
          if (xfer) begin
            out_v          <= 1'b0;
            ticks_mem[idx] <= period_mem[idx];
            if (last)
              state <= ST_IDLE;
            else begin
              state <= ST_SCAN;
              idx   <= idx + Ngens'(1);
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef SPIKE_GEN_STATS_EN
  always_ff @(posedge clk) begin
    if (reset || clear_stats)
      spike_count <= '0;
    else if (xfer)
      spike_count <= spike_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_spike_gen_scheduler.sv
// tb_spike_gen_scheduler
//   Drives spike_gen_scheduler with directed and randomized programming,
//   pulses and back-pressure; compares emitted events against a per-generator
//   countdown model evaluated once per scan.
module tb_spike_gen_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        time_unit_pulse = 1'b0;
  logic [7:0]  prog_gen_idx = '0;
  logic [15:0] prog_period = '0;
  logic [15:0] prog_ticks = '0;
  logic [10:0] prog_tag = '0;
  logic        prog_v = 1'b0;
  logic        prog_a;
  logic [10:0] out_tag;
  logic [9:0]  out_ct;
  logic        out_v;
  logic        out_a = 1'b0;
  logic        busy;
  logic        overrun;
`ifdef SPIKE_GEN_STATS_EN
  logic [31:0] spike_count;
  logic        clear_stats = 1'b0;
`endif

  int errors = 0;
  int checks = 0;
  int a_mode = 0;  // 0: out_a low, 1: out_a high, 2: random

  bit          m_en     [256];
  int unsigned m_period [256];
  int unsigned m_ticks  [256];
  int unsigned m_tag    [256];
  int unsigned exp_q[$];
  int unsigned obs_tag[$];
  int unsigned obs_ct[$];

  spike_gen_scheduler #(.Ngens(8), .Nperiod(16), .Ntag(11), .Nct(10)) dut (
    .clk(clk), .reset(reset), .time_unit_pulse(time_unit_pulse),
    .prog_gen_idx(prog_gen_idx), .prog_period(prog_period),
    .prog_ticks(prog_ticks), .prog_tag(prog_tag), .prog_v(prog_v),
    .prog_a(prog_a), .out_tag(out_tag), .out_ct(out_ct), .out_v(out_v),
    .out_a(out_a), .busy(busy), .overrun(overrun)
`ifdef SPIKE_GEN_STATS_EN
    , .spike_count(spike_count), .clear_stats(clear_stats)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (a_mode == 0)      out_a = 1'b0;
    else if (a_mode == 1) out_a = 1'b1;
    else                  out_a = 1'($urandom_range(0, 1));
  end

  // A transfer seen at negedge completes on the following rising edge
  always @(negedge clk) begin
    if (!reset && out_v && out_a) begin
      obs_tag.push_back(int'(out_tag));
      obs_ct.push_back(int'(out_ct));
    end
  end

  function automatic void model_clear();
    for (int unsigned g = 0; g < 256; g++) m_en[g] = 1'b0;
    exp_q.delete();
    obs_tag.delete();
    obs_ct.delete();
  endfunction

  // One time unit: every enabled generator counts down; expired ones fire and reload
  function automatic void model_scan();
    for (int unsigned g = 0; g < 256; g++) begin
      if (m_en[g]) begin
        if (m_ticks[g] <= 1) begin
          exp_q.push_back(m_tag[g]);
          m_ticks[g] = m_period[g];
        end else begin
          m_ticks[g] = m_ticks[g] - 1;
        end
      end
    end
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model_clear();
  endtask

  task automatic prog_write(input int unsigned g, input int unsigned p,
                            input int unsigned t, input int unsigned tg);
    int n = 0;
    prog_gen_idx = 8'(g); prog_period = 16'(p); prog_ticks = 16'(t);
    prog_tag = 11'(tg); prog_v = 1'b1;
    forever begin
      @(negedge clk);
      if (prog_a) break;
      n++;
      if (n > 2000) begin
        errors++; checks++;
        $display("FAIL prog_wait: prog_a never rose, waited %0d cycles, required <= 2000", n);
        break;
      end
    end
    @(posedge clk); #1 prog_v = 1'b0;
    m_en[g] = (p != 0); m_period[g] = p; m_ticks[g] = t; m_tag[g] = tg;
  endtask

  task automatic pulse();
    time_unit_pulse = 1'b1;
    @(posedge clk); #1 time_unit_pulse = 1'b0;
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    forever begin
      @(negedge clk);
      if (!busy) break;
      cycles++;
      if (cycles > 5000) begin
        errors++; checks++;
        $display("FAIL idle_wait: busy stuck high for %0d cycles, required <= 5000", cycles);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (prog_a !== 1'b0) begin
      errors++; $display("FAIL reset_prog_a: got %b required 0", prog_a);
    end
    @(posedge clk); #1 reset = 1'b0;
    model_clear();
    @(negedge clk);
    checks++;
    if ({out_v, out_tag, out_ct, busy, overrun} !== '0) begin
      errors++;
      $display("FAIL reset_state: v=%b tag=%h ct=%h busy=%b ovr=%b required all 0",
               out_v, out_tag, out_ct, busy, overrun);
    end
    checks++;
    if (prog_a !== 1'b1) begin
      errors++; $display("FAIL reset_idle_prog_a: got %b required 1", prog_a);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_periodic();
    int cyc;
    int unsigned want;
    do_reset();
    a_mode = 1;
    prog_write(3, 4, 2, 11'h155);
    for (int p = 1; p <= 10; p++) begin
      pulse();
      wait_idle(cyc);
      want = (p >= 2 ? 1 : 0) + (p >= 6 ? 1 : 0) + (p >= 10 ? 1 : 0);
      checks++;
      if (obs_tag.size() != want) begin
        errors++;
        $display("FAIL periodic_count pulse %0d: got %0d events required %0d", p, obs_tag.size(), want);
      end
    end
    for (int i = 0; i < obs_tag.size(); i++) begin
      checks++;
      if (obs_tag[i] != 32'h155 || obs_ct[i] != 1) begin
        errors++;
        $display("FAIL periodic_event %0d: tag=%h ct=%0d required tag=155 ct=1", i, obs_tag[i], obs_ct[i]);
      end
    end
  endtask

  task automatic test_boundary_gens();
    int cyc;
    do_reset();
    a_mode = 1;
    prog_write(0, 1, 1, 11'h001);
    prog_write(255, 1, 1, 11'h7FF);
    pulse(); model_scan();
    wait_idle(cyc);
    checks++;
    if (cyc != 258) begin
      errors++; $display("FAIL boundary_busy: busy for %0d cycles required 258", cyc);
    end
    checks++;
    if (obs_tag.size() != 2) begin
      errors++; $display("FAIL boundary_count: got %0d events required 2", obs_tag.size());
    end else begin
      checks++;
      if (obs_tag[0] != 32'h001 || obs_tag[1] != 32'h7FF || obs_tag[0] != exp_q[0] || obs_tag[1] != exp_q[1]) begin
        errors++;
        $display("FAIL boundary_order: got %h,%h required 001,7ff", obs_tag[0], obs_tag[1]);
      end
    end
  endtask

  task automatic test_stall();
    int cyc;
    int n = 0;
    bit stable = 1'b1;
    logic [10:0] t0;
    do_reset();
    a_mode = 0;
    prog_write(0, 1, 1, 11'h001);
    prog_write(255, 1, 1, 11'h7FF);
    pulse(); model_scan();
    forever begin
      @(negedge clk);
      if (out_v) break;
      n++;
      if (n > 50) begin
        errors++; checks++;
        $display("FAIL stall_wait: out_v never rose in %0d cycles, required <= 50", n);
        break;
      end
    end
    t0 = out_tag;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_v !== 1'b1 || out_tag !== t0) stable = 1'b0;
      @(posedge clk); #1;
      time_unit_pulse = (i == 5 || i == 10);
    end
    time_unit_pulse = 1'b0;
    checks++;
    if (!stable || t0 !== 11'h001) begin
      errors++; $display("FAIL stall_hold: stable=%b tag=%h required stable=1 tag=001", stable, t0);
    end
    @(negedge clk);
    checks++;
    if (overrun !== 1'b1) begin
      errors++; $display("FAIL stall_overrun: got %b required 1", overrun);
    end
    @(posedge clk); #1;
    a_mode = 1;
    model_scan();
    wait_idle(cyc);
    repeat (3) @(posedge clk);
    #1 wait_idle(cyc);
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (obs_tag.size() != exp_q.size()) begin
      errors++; $display("FAIL stall_count: got %0d events required %0d", obs_tag.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (obs_tag[i] != exp_q[i] || obs_ct[i] != 1) begin
          errors++;
          $display("FAIL stall_event %0d: tag=%h ct=%0d required tag=%h ct=1", i, obs_tag[i], obs_ct[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_disable();
    int cyc;
    do_reset();
    a_mode = 1;
    prog_write(5, 2, 1, 11'h0A5);
    pulse(); model_scan(); wait_idle(cyc);
    prog_write(5, 0, 3, 11'h0A5);
    repeat (3) begin
      pulse(); model_scan(); wait_idle(cyc);
    end
    checks++;
    if (obs_tag.size() != 1 || exp_q.size() != 1) begin
      errors++; $display("FAIL disable_count: got %0d events required 1", obs_tag.size());
    end else begin
      checks++;
      if (obs_tag[0] != exp_q[0]) begin
        errors++; $display("FAIL disable_tag: got %h required %h", obs_tag[0], exp_q[0]);
      end
    end
  endtask

  task automatic test_prog_during_scan();
    int cyc;
    int n = 0;
    bit leaked = 1'b0;
    do_reset();
    a_mode = 1;
    pulse();
    prog_gen_idx = 8'd20; prog_period = 16'd1; prog_ticks = 16'd1;
    prog_tag = 11'h2AA; prog_v = 1'b1;
    forever begin
      @(negedge clk);
      if (!busy) break;
      if (prog_a) leaked = 1'b1;
      n++;
      if (n > 1000) begin
        errors++; checks++;
        $display("FAIL scan_prog_wait: busy high for %0d cycles, required <= 1000", n);
        break;
      end
    end
    checks++;
    if (leaked) begin
      errors++; $display("FAIL scan_prog_a: prog_a was 1 during scan, required 0");
    end
    checks++;
    if (prog_a !== 1'b1) begin
      errors++; $display("FAIL idle_prog_a: got %b required 1", prog_a);
    end
    @(posedge clk); #1 prog_v = 1'b0;
    m_en[20] = 1'b1; m_period[20] = 1; m_ticks[20] = 1; m_tag[20] = 11'h2AA;
    pulse(); model_scan(); wait_idle(cyc);
    checks++;
    if (obs_tag.size() != 1 || exp_q.size() != 1 || obs_tag[0] != exp_q[0]) begin
      errors++;
      $display("FAIL scan_prog_write: got %0d events first=%h required 1 event tag=2aa",
               obs_tag.size(), obs_tag.size() > 0 ? obs_tag[0] : 0);
    end
  endtask

  task automatic test_reset_in_emit();
    int cyc;
    int n = 0;
    do_reset();
    a_mode = 0;
    prog_write(7, 1, 1, 11'h3C3);
    prog_write(100, 3, 1, 11'h011);
    pulse();
    forever begin
      @(negedge clk);
      if (out_v) break;
      n++;
      if (n > 50) begin
        errors++; checks++;
        $display("FAIL emit_wait: out_v never rose in %0d cycles, required <= 50", n);
        break;
      end
    end
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    model_clear();
    @(negedge clk);
    checks++;
    if (out_v !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL emit_reset: out_v=%b busy=%b required 0 0", out_v, busy);
    end
    @(posedge clk); #1;
    a_mode = 1;
    repeat (2) begin
      pulse(); model_scan(); wait_idle(cyc);
    end
    checks++;
    if (obs_tag.size() != 0 || exp_q.size() != 0) begin
      errors++; $display("FAIL emit_reset_events: got %0d events required 0", obs_tag.size());
    end
  endtask

  task automatic test_random();
    int cyc;
    do_reset();
    a_mode = 2;
    repeat (14) prog_write($urandom_range(0, 255), $urandom_range(0, 4),
                           $urandom_range(0, 4), $urandom_range(0, 2047));
    repeat (8) begin
      pulse(); model_scan(); wait_idle(cyc);
    end
    checks++;
    if (obs_tag.size() != exp_q.size()) begin
      errors++; $display("FAIL random_count: got %0d events required %0d", obs_tag.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (obs_tag[i] != exp_q[i] || obs_ct[i] != 1) begin
          errors++;
          $display("FAIL random_event %0d: tag=%h ct=%0d required tag=%h ct=1", i, obs_tag[i], obs_ct[i], exp_q[i]);
        end
      end
    end
`ifdef SPIKE_GEN_STATS_EN
    checks++;
    if (spike_count != 32'(exp_q.size())) begin
      errors++; $display("FAIL random_stats: got %0d required %0d", spike_count, exp_q.size());
    end
`endif
    a_mode = 1;
  endtask

  initial begin
    test_reset();
    test_periodic();
    test_boundary_gens();
    test_stall();
    test_disable();
    test_prog_during_scan();
    test_reset_in_emit();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
